// File: rtl/hazard_ctrl_unit.sv
// Hazard, forwarding and flush control for a 5-stage pipeline: stall/flush are same-cycle,
// forwarding selects are registered so they line up with the instruction entering EX.
module hazard_ctrl_unit #(
   parameter int REG_AW       = 5,
   parameter int DEPTH        = 3,
   parameter int LOAD_STAGE   = 1,
   parameter int WB_BYPASS    = 0,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16,
   parameter int FW           = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1_ad,
   input  logic [REG_AW-1:0] id_rs2_ad,
   input  logic              id_rs1_read,
   input  logic              id_rs2_read,
   input  logic [REG_AW-1:0] id_rd_ad,
   input  logic              id_rdEn,
   input  logic              id_is_load,
   input  logic              ex_branch_taken,
   output logic              stall,
   output logic              flush,
   output logic [FW-1:0]     fwd_a,
   output logic [FW-1:0]     fwd_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic [DEPTH-1:0]  r_vld;
   logic [DEPTH-1:0]  r_wr;
   logic [DEPTH-1:0]  r_ld;
   logic [REG_AW-1:0] r_rd [DEPTH];
   logic [2:0]        r_timer;
   logic [FW-1:0]     r_fwd_a;
   logic [FW-1:0]     r_fwd_b;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;

   logic              w_stl_a;
   logic              w_stl_b;
   logic [FW-1:0]     w_sel_a;
   logic [FW-1:0]     w_sel_b;
   logic              w_flush;
   logic              w_stall;
   logic              w_enter;

   // Scan oldest to youngest so the youngest matching stage is the last one written.
   always_comb begin
      w_stl_a = 1'b0;
      w_stl_b = 1'b0;
      w_sel_a = '0;
      w_sel_b = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (r_vld[i] && r_wr[i] && id_rs1_read && id_rs1_ad != '0 && r_rd[i] == id_rs1_ad) begin
            w_stl_a = (r_ld[i] && i < LOAD_STAGE) || (i == DEPTH - 1 && WB_BYPASS == 0);
            w_sel_a = (i < DEPTH - 1) ? FW'(i + 1) : '0;
         end
         if (r_vld[i] && r_wr[i] && id_rs2_read && id_rs2_ad != '0 && r_rd[i] == id_rs2_ad) begin
            w_stl_b = (r_ld[i] && i < LOAD_STAGE) || (i == DEPTH - 1 && WB_BYPASS == 0);
            w_sel_b = (i < DEPTH - 1) ? FW'(i + 1) : '0;
         end
      end
   end

   assign w_flush = ex_branch_taken || (r_timer != 3'd0);
   assign w_stall = id_valid && (w_stl_a || w_stl_b) && !w_flush;
   assign w_enter = id_valid && !w_stall && !w_flush;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_vld       <= '0;
         r_wr        <= '0;
         r_ld        <= '0;
         for (int i = 0; i < DEPTH; i++) r_rd[i] <= '0;
         r_timer     <= 3'd0;
         r_fwd_a     <= '0;
         r_fwd_b     <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_vld <= {r_vld[DEPTH-2:0], w_enter};
         r_wr  <= {r_wr[DEPTH-2:0], w_enter && id_rdEn && id_rd_ad != '0};
         r_ld  <= {r_ld[DEPTH-2:0], w_enter && id_is_load};
         for (int i = DEPTH - 1; i > 0; i--) r_rd[i] <= r_rd[i-1];
         r_rd[0] <= w_enter ? id_rd_ad : '0;

         // A new taken branch restarts the stretch even if one is already running.
         if (ex_branch_taken)
            r_timer <= 3'(FLUSH_CYCLES - 1);
         else if (r_timer != 3'd0)
            r_timer <= r_timer - 3'd1;

         r_fwd_a <= w_enter ? w_sel_a : '0;
         r_fwd_b <= w_enter ? w_sel_b : '0;

         if (w_stall && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush && r_flush_cnt != '1)
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stall     = w_stall;
   assign flush     = w_flush;
   assign fwd_a     = r_fwd_a;
   assign fwd_b     = r_fwd_b;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two differently configured instances share one stimulus stream;
// a history-based reference model queues expected outputs and a monitor compares each cycle.
module tb_hazard_ctrl_unit;

   localparam int NI = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs1_ad = '0;
   logic [4:0] id_rs2_ad = '0;
   logic       id_rs1_read = 1'b0;
   logic       id_rs2_read = 1'b0;
   logic [4:0] id_rd_ad = '0;
   logic       id_rdEn = 1'b0;
   logic       id_is_load = 1'b0;
   logic       ex_branch_taken = 1'b0;

   logic        stall0, flush0, stall1, flush1;
   logic [1:0]  fa0, fb0, fa1, fb1;
   logic [15:0] sc0, fc0;
   logic [3:0]  sc1, fc1;

   always #5 clk = ~clk;

   hazard_ctrl_unit dut0 (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs1_ad(id_rs1_ad), .id_rs2_ad(id_rs2_ad),
      .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read),
      .id_rd_ad(id_rd_ad), .id_rdEn(id_rdEn), .id_is_load(id_is_load),
      .ex_branch_taken(ex_branch_taken),
      .stall(stall0), .flush(flush0), .fwd_a(fa0), .fwd_b(fb0),
      .stall_cnt(sc0), .flush_cnt(fc0)
   );

   hazard_ctrl_unit #(.WB_BYPASS(1), .FLUSH_CYCLES(2), .CNT_W(4)) dut1 (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs1_ad(id_rs1_ad), .id_rs2_ad(id_rs2_ad),
      .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read),
      .id_rd_ad(id_rd_ad), .id_rdEn(id_rdEn), .id_is_load(id_is_load),
      .ex_branch_taken(ex_branch_taken),
      .stall(stall1), .flush(flush1), .fwd_a(fa1), .fwd_b(fb1),
      .stall_cnt(sc1), .flush_cnt(fc1)
   );

   // Reference model: a list of the last three instructions to enter EX (index 0 = youngest).
   typedef struct { bit vld; bit wr; bit ld; int rd; } ent_t;
   typedef struct { bit stall; bit flush; bit chk_fwd; int fa; int fb; int sc; int fc; } exp_t;

   ent_t pipe [NI][3];
   int   m_fa [NI];
   int   m_fb [NI];
   int   m_timer [NI];
   int   m_sc [NI];
   int   m_fc [NI];
   bit   m_chk [NI];
   bit   m_stall [NI];
   int   wbb  [NI] = '{0, 1};
   int   fcyc [NI] = '{1, 2};
   int   cmax [NI] = '{65535, 15};
   exp_t q0[$];
   exp_t q1[$];
   bit   arm = 1'b0;

   int nvec = 0;
   int nerr = 0;

   function automatic int youngest(int p, int rs, bit rdf);
      if (!rdf || rs == 0) return -1;
      for (int k = 0; k < 3; k++)
         if (pipe[p][k].vld && pipe[p][k].wr && pipe[p][k].rd == rs) return k;
      return -1;
   endfunction

   function automatic bit needs_stall(int p, int k);
      if (k < 0) return 1'b0;
      return (pipe[p][k].ld && k < 1) || (k == 2 && wbb[p] == 0);
   endfunction

   task automatic model_step();
      for (int p = 0; p < NI; p++) begin
         exp_t e;
         int   ka, kb;
         bit   enter;
         ka = youngest(p, int'(id_rs1_ad), id_rs1_read);
         kb = youngest(p, int'(id_rs2_ad), id_rs2_read);
         e.flush   = ex_branch_taken || m_timer[p] != 0;
         e.stall   = id_valid && (needs_stall(p, ka) || needs_stall(p, kb)) && !e.flush;
         e.chk_fwd = m_chk[p];
         e.fa      = m_fa[p];
         e.fb      = m_fb[p];
         e.sc      = m_sc[p];
         e.fc      = m_fc[p];
         if (arm) begin
            if (p == 0) q0.push_back(e);
            else        q1.push_back(e);
         end
         m_stall[p] = e.stall;
         if (!reset) begin
            for (int k = 0; k < 3; k++) pipe[p][k] = '{0, 0, 0, 0};
            m_fa[p] = 0; m_fb[p] = 0; m_timer[p] = 0; m_sc[p] = 0; m_fc[p] = 0;
            m_chk[p] = 1'b1;
         end else begin
            enter = id_valid && !e.stall && !e.flush;
            pipe[p][2] = pipe[p][1];
            pipe[p][1] = pipe[p][0];
            if (enter)
               pipe[p][0] = '{1, id_rdEn && id_rd_ad != 0, id_is_load, int'(id_rd_ad)};
            else
               pipe[p][0] = '{0, 0, 0, 0};
            m_fa[p]  = (enter && ka >= 0 && ka < 2) ? ka + 1 : 0;
            m_fb[p]  = (enter && kb >= 0 && kb < 2) ? kb + 1 : 0;
            m_chk[p] = enter || e.stall || e.flush;
            if (ex_branch_taken)     m_timer[p] = fcyc[p] - 1;
            else if (m_timer[p] > 0) m_timer[p] = m_timer[p] - 1;
            if (e.stall && m_sc[p] < cmax[p]) m_sc[p]++;
            if (e.flush && m_fc[p] < cmax[p]) m_fc[p]++;
         end
      end
   endtask

   task automatic drive(bit rst, bit v, int r1, int r2, bit e1, bit e2, int rd, bit we, bit ld, bit br);
      @(posedge clk);
      #1;
      reset           = !rst;
      id_valid        = v;
      id_rs1_ad       = 5'(r1);
      id_rs2_ad       = 5'(r2);
      id_rs1_read     = e1;
      id_rs2_read     = e2;
      id_rd_ad        = 5'(rd);
      id_rdEn         = we;
      id_is_load      = ld;
      ex_branch_taken = br;
      model_step();
   endtask

   // Holds an instruction in ID until neither model reports a stall, like a real pipeline would.
   task automatic instr(int r1, int r2, bit e1, bit e2, int rd, bit we, bit ld);
      drive(0, 1, r1, r2, e1, e2, rd, we, ld, 0);
      for (int n = 0; n < 4 && (m_stall[0] || m_stall[1]); n++)
         drive(0, 1, r1, r2, e1, e2, rd, we, ld, 0);
   endtask

   task automatic idle(int n);
      repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic chk(string nm, int act, int exp_v);
      nvec++;
      if (act != exp_v) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("d0.stall", int'(stall0), int'(e.stall));
            chk("d0.flush", int'(flush0), int'(e.flush));
            chk("d0.stall_cnt", int'(sc0), e.sc);
            chk("d0.flush_cnt", int'(fc0), e.fc);
            if (e.chk_fwd) begin
               chk("d0.fwd_a", int'(fa0), e.fa);
               chk("d0.fwd_b", int'(fb0), e.fb);
            end
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("d1.stall", int'(stall1), int'(e.stall));
            chk("d1.flush", int'(flush1), int'(e.flush));
            chk("d1.stall_cnt", int'(sc1), e.sc);
            chk("d1.flush_cnt", int'(fc1), e.fc);
            if (e.chk_fwd) begin
               chk("d1.fwd_a", int'(fa1), e.fa);
               chk("d1.fwd_b", int'(fb1), e.fb);
            end
         end
      end
   end

   initial begin : stimulus
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      arm = 1'b1;
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // add x5,x1,x2 ; sub x6,x5,x3
      instr(1, 2, 1, 1, 5, 1, 0);
      instr(5, 3, 1, 1, 6, 1, 0);
      idle(3);
      // lw x7 ; add x8,x7,x7
      instr(1, 0, 1, 0, 7, 1, 1);
      instr(7, 7, 1, 1, 8, 1, 0);
      idle(3);
      // writer x9, two unrelated, reader x9
      instr(1, 2, 1, 1, 9, 1, 0);
      instr(1, 2, 1, 1, 10, 1, 0);
      instr(3, 4, 1, 1, 11, 1, 0);
      instr(9, 2, 1, 0, 12, 1, 0);
      idle(3);
      // taken branch arriving during a load-use stall, then a retrigger
      instr(1, 0, 1, 0, 13, 1, 1);
      drive(0, 1, 13, 0, 1, 0, 14, 1, 0, 1);
      drive(0, 1, 13, 0, 1, 0, 14, 1, 0, 0);
      idle(3);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(3);
      // x0 writes and reads
      instr(1, 0, 1, 0, 0, 1, 0);
      instr(0, 0, 1, 1, 3, 1, 0);
      instr(1, 0, 1, 0, 0, 1, 1);
      instr(0, 0, 1, 1, 4, 1, 0);
      idle(3);
      // reset mid-stream with a load in flight and the flush stretch running
      instr(1, 0, 1, 0, 15, 1, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(1, 1, 15, 15, 1, 1, 16, 1, 0, 0);
      drive(0, 1, 15, 15, 1, 1, 16, 1, 0, 0);
      idle(2);
      // 20 load-use stalls to saturate the narrow counter
      for (int n = 0; n < 20; n++) begin
         instr(1, 0, 1, 0, 7, 1, 1);
         instr(7, 2, 1, 1, 8, 1, 0);
      end
      idle(3);

      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
               int'($urandom_range(0, 7)), $urandom_range(0, 5) != 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0);
      end
      idle(3);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised hazard, forwarding and flush controller for the 5-stage RISC-V pipeline; replaces the combinational forwarding unit.
- Tracks in-flight destination writes in a DEPTH-entry shadow shift register.
- Issues load-use and writeback stalls, and registered EX-aligned forwarding selects for both ALU operands.
- Stretches branch flush over a configurable number of cycles and keeps saturating stall/flush counters.

Parameters:
- REG_AW, 5: register address width (2^REG_AW architectural registers, x0 hardwired zero).
- DEPTH, 3: tracked stages after ID (stg0=EX, stg1=MEM, stg2=WB); minimum 2.
- LOAD_STAGE, 1: lowest stage index from which a load result is forwardable.
- WB_BYPASS, 0: 1 = register file writes through on the same cycle, so no WB-stage stall is needed.
- FLUSH_CYCLES, 1: cycles flush stays high per taken branch (1..7).
- CNT_W, 16: performance counter width.
- FW, $clog2(DEPTH): forwarding select width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1_ad  in  REG_AW  ID source 1 address
- id_rs2_ad  in  REG_AW  ID source 2 address
- id_rs1_read  in  1  ID instruction reads rs1
- id_rs2_read  in  1  ID instruction reads rs2
- id_rd_ad  in  REG_AW  ID destination address
- id_rdEn  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- flush  out  1  kill IF/ID and ID/EX contents
- fwd_a  out  FW  EX operand A source: 0=regfile value, k=result held in stage k
- fwd_b  out  FW  EX operand B source, same encoding
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of flush cycles

Behaviour:
Reset and update
- Reset (reset==0 at a clk edge): all stg entries invalid, fwd_a=fwd_b=0, flush timer=0, stall_cnt=flush_cnt=0.
- Reset mid-operation discards all tracked writes; the next cycle's stall and flush are 0.
- Each stg entry holds {valid, rd_ad, wr, load}. wr = rdEn && rd_ad!=0.

Hazard match and stall
- Match on operand X at stage i: stg[i].valid, stg[i].wr, stg[i].rd_ad==id_rsX_ad, id_rsX_read, id_rsX_ad!=0.
- The youngest match (lowest i) wins per operand.
- stall_X = youngest match has (stg[i].load && i<LOAD_STAGE), or (i==DEPTH-1 && WB_BYPASS==0).
- stall = id_valid && (stall_a||stall_b) && !flush. Stall is combinational, same cycle.

Flush
- flush = ex_branch_taken || timer!=0.
- On ex_branch_taken, timer <= FLUSH_CYCLES-1, overriding any running timer (a retrigger restarts it).
- Otherwise timer decrements to 0.
- Flush has priority over stall.

Stage advance (every cycle, no global enable)
- stg[i+1] <= stg[i].
- stg[0] <= ID instruction if id_valid && !stall && !flush; otherwise an invalid bubble.

Forwarding selects (registered, aligned with the instruction entering EX)
- Youngest match i < DEPTH-1 loads fwd = i+1.
- No match, or a match at DEPTH-1 with WB_BYPASS=1, loads fwd = 0.
- fwd loads 0 when a bubble is inserted (stall or flush).
- A match at DEPTH-1 with WB_BYPASS=0 is covered by the stall, so fwd=0 on retry.
- The operand read flag low forces its fwd to 0.

Counters
- stall_cnt increments on each stall cycle; flush_cnt increments on each flush cycle.
- Both saturate at 2^CNT_W-1 and never wrap.

Simultaneous events
- A branch during a load-use stall: flush wins, the stalled ID instruction is killed, stall_cnt does not increment that cycle.
- Both operands hazarded: a single stall.
- rs1==rs2 matching: both fwd get the same value.

Test Plan:
1. Defaults. ID `add x5,x1,x2`, then ID `sub x6,x5,x3` next cycle -> stall=0; the cycle sub enters EX, fwd_a=1, fwd_b=0.
2. `lw x7,0(x1)` then `add x8,x7,x7` -> stall=1 for exactly 1 cycle, stall_cnt=1; then fwd_a=fwd_b=2 when add enters EX.
3. Writer to x9, two unrelated instructions, then a reader of x9 -> with WB_BYPASS=0, stall=1 for 1 cycle, then fwd_a=0; repeat with WB_BYPASS=1 -> no stall, fwd_a=0.
4. FLUSH_CYCLES=2, ex_branch_taken pulsed 1 cycle while a load-use stall is pending -> flush high 2 cycles, stall=0 during flush, flush_cnt=2, stg[0] bubble both cycles.
5. Writes to x0 followed by reads of x0 -> stall=0, fwd_a=fwd_b=0 throughout.
6. reset driven low for 1 cycle mid-stream, with a load in stg0 and the flush timer at 1 -> next cycle stall=0, flush=0, fwd=0, counters=0; CNT_W=4 with 20 stalls -> stall_cnt holds at 15.
